mano_boot_loader: RTL and testbench
===================================

Name: mano_boot_loader

Overview:
Upstream program loader and memory-port arbiter for the Mano CPU core.
- Holds the CPU in reset while it streams a program image into the shared single-port SRAM from address 0.
- Releases the CPU and hands it the SRAM port.
- On request, re-asserts CPU reset and streams a memory region back out for inspection.

Parameters:
- DWIDTH, 32, SRAM and CPU data width.
- AWIDTH, 12, SRAM address width.
- MEM_SIZE, 4096, number of SRAM words; the last valid address is MEM_SIZE-1.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- s_valid  input  1  load stream word valid.
- s_ready  output  1  load stream ready.
- s_data  input  DWIDTH  load stream word.
- s_last  input  1  marks the final word of the image.
- run_req  input  1  pulse; release the CPU after a completed load.
- dump_req  input  1  pulse; halt the CPU and start a dump.
- dump_len  input  AWIDTH+1  number of words to dump, starting at address 0.
- m_valid  output  1  dump stream valid.
- m_ready  input  1  dump stream ready.
- m_data  output  DWIDTH  dump stream word.
- cpu_reset_n  output  1  active-low reset to the CPU.
- cpu_ar  input  AWIDTH  CPU address.
- cpu_din  input  DWIDTH  CPU write data.
- cpu_we  input  1  CPU write enable.
- cpu_dout  output  DWIDTH  SRAM read data to the CPU; wired directly to mem_dout.
- mem_addr  output  AWIDTH  SRAM address.
- mem_din  output  DWIDTH  SRAM write data.
- mem_we  output  1  SRAM write enable.
- mem_dout  input  DWIDTH  SRAM read data; synchronous, valid one cycle after mem_addr.
- state_o  output  3  current FSM state.
- load_err  output  1  sticky flag: image overflowed the SRAM.

Behaviour:
- Reset values:
  - state IDLE, cpu_reset_n 0, s_ready 0, m_valid 0, m_data 0.
  - mem_we 0, mem_addr 0, mem_din 0.
  - load_err 0, load pointer 0, dump pointer 0.
- States: IDLE(0), LOAD(1), LOADED(2), RUN(3), DUMP_RD(4), DUMP_WAIT(5), DUMP_OUT(6).
- Port mux:
  - In RUN, mem_addr/mem_din/mem_we = cpu_ar/cpu_din/cpu_we, combinationally.
  - In every other state the loader drives the port registered, and cpu_reset_n=0.
- IDLE:
  - s_valid=1 -> LOAD; the pointer clears to 0.
  - dump_req=1 -> DUMP_RD.
- LOAD:
  - s_ready=1.
  - Each s_valid&&s_ready beat writes s_data at the pointer (mem_we=1 for exactly that cycle), then increments the pointer.
  - s_last on an accepted beat -> LOADED.
  - If the pointer is already MEM_SIZE-1 and the beat is not last: the word is written, load_err sets, and later beats are accepted and discarded (no write) until s_last. There is no wrap.
- LOADED:
  - run_req -> RUN. cpu_reset_n rises on the cycle after the transition, so the CPU leaves reset with PC=0.
  - dump_req -> DUMP_RD.
  - A new s_valid -> LOAD; this is a reload starting from 0 and clears load_err.
- RUN:
  - dump_req -> DUMP_RD. cpu_reset_n drops in the same cycle as the transition, and any CPU write issued that cycle is still performed.
  - run_req in RUN is ignored.
- Dump:
  - DUMP_RD presents the dump pointer on mem_addr, then DUMP_WAIT.
  - DUMP_WAIT captures mem_dout into m_data, asserts m_valid, then DUMP_OUT.
  - DUMP_OUT holds m_valid and m_data stable until m_ready.
  - On handshake: the pointer increments. If the pointer reaches dump_len (sampled at dump start), go to LOADED; otherwise go to DUMP_RD.
  - dump_len=0 -> return to LOADED immediately with no m_valid.
  - Throughput is at most 1 word per 3 cycles.
- Simultaneous dump_req and run_req in LOADED: dump_req wins.
- reset mid-operation: returns to IDLE immediately. Any partial load is abandoned and the SRAM contents are unchanged.

Optional Feature:
- Macro: LOAD_CHECKSUM_EN.
- When defined:
  - Adds output load_sum[DWIDTH-1:0], the modulo-2^DWIDTH sum of every word actually written during the current load.
  - load_sum clears on entry to LOAD and on reset.
  - load_sum is stable from LOADED onward.
- When undefined: the port and its logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package mano_pkg holds:
  - the state enum/localparams (IDLE..DUMP_OUT);
  - the DWIDTH/AWIDTH/MEM_SIZE defaults shared with the CPU.
- One sub-module is natural: mano_mem_mux, the combinational RUN/loader port select. Everything else stays in the top.

Test Plan:
- Load 4 words 0x1000,0x2001,0x7020,0x4003 with no backpressure (last on 4th) -> SRAM[0..3] holds those values, state LOADED, load_err=0, cpu_reset_n=0.
- run_req after the load -> cpu_reset_n=1 one cycle later; a CPU write of 0xABCD to address 10 lands in SRAM[10].
- dump_req in RUN with dump_len=4 and m_ready toggling 1/0 -> m_data sequence 0x1000,0x2001,0x7020,0x4003, with m_data held while m_ready=0, then LOADED and cpu_reset_n=0.
- Stream MEM_SIZE+2 words -> load_err=1, SRAM[MEM_SIZE-1] holds word MEM_SIZE-1, SRAM[0] untouched by the overflow beats.
- reset asserted mid-LOAD after 2 beats -> state IDLE, s_ready=0, mem_we=0 in the same cycle.
- With LOAD_CHECKSUM_EN, load 0xFFFFFFFF and 0x00000002 -> load_sum=0x00000001.

Source files
------------

// File: rtl/mano_pkg.sv
// Shared Mano definitions: default bus sizes and the loader FSM encoding.
package mano_pkg;

  localparam int MANO_DWIDTH   = 32;
  localparam int MANO_AWIDTH   = 12;
  localparam int MANO_MEM_SIZE = 4096;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    LOADED    = 3'd2,
    RUN       = 3'd3,
    DUMP_RD   = 3'd4,
    DUMP_WAIT = 3'd5,
    DUMP_OUT  = 3'd6
  } state_t;

endpackage

// File: rtl/mano_mem_mux.sv
// SRAM port select: the CPU owns the port combinationally while running,
// otherwise the loader's registered request drives it.
module mano_mem_mux
  import mano_pkg::*;
#(
  parameter int DWIDTH = MANO_DWIDTH,
  parameter int AWIDTH = MANO_AWIDTH
) (
  input  logic              run_sel,
  input  logic [AWIDTH-1:0] cpu_ar,
  input  logic [DWIDTH-1:0] cpu_din,
  input  logic              cpu_we,
  input  logic [AWIDTH-1:0] ld_addr,
  input  logic [DWIDTH-1:0] ld_din,
  input  logic              ld_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_din,
  output logic              mem_we
);

  // Pick the port owner
  always_comb begin
    mem_addr = ld_addr;
    mem_din  = ld_din;
    mem_we   = ld_we;
    if (run_sel) begin
      mem_addr = cpu_ar;
      mem_din  = cpu_din;
      mem_we   = cpu_we;
    end
  end

endmodule

// File: rtl/mano_boot_loader.sv
// Program loader / SRAM arbiter for the Mano CPU.
// Streams an image into SRAM from address 0 with the CPU in reset, releases
// the CPU on run_req, and on dump_req halts it and streams words 0..len-1 out.
// Optional: define LOAD_CHECKSUM_EN to add the load_sum output.
module mano_boot_loader
  import mano_pkg::*;
#(
  parameter int DWIDTH   = MANO_DWIDTH,
  parameter int AWIDTH   = MANO_AWIDTH,
  parameter int MEM_SIZE = MANO_MEM_SIZE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DWIDTH-1:0] s_data,
  input  logic              s_last,
  input  logic              run_req,
  input  logic              dump_req,
  input  logic [AWIDTH:0]   dump_len,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic              cpu_reset_n,
  input  logic [AWIDTH-1:0] cpu_ar,
  input  logic [DWIDTH-1:0] cpu_din,
  input  logic              cpu_we,
  output logic [DWIDTH-1:0] cpu_dout,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_din,
  output logic              mem_we,
  input  logic [DWIDTH-1:0] mem_dout,
`ifdef LOAD_CHECKSUM_EN
  output logic [DWIDTH-1:0] load_sum,
`endif
  output logic [2:0]        state_o,
  output logic              load_err
);

  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(MEM_SIZE - 1);
  localparam logic [AWIDTH:0]   DONE_ONE  = (AWIDTH+1)'(1);

  state_t            state, state_d;
  logic              start_load, start_dump;
  logic              beat, load_wr, dump_last;
  logic [AWIDTH-1:0] ld_ptr, ld_addr;
  logic [DWIDTH-1:0] ld_din;
  logic              ld_we;
  logic [AWIDTH:0]   dump_ptr, dump_len_q, dump_nxt;

  // Once the last address is filled the rest of the image is swallowed
  assign beat      = (state == LOAD) && s_valid;
  assign load_wr   = beat && !load_err;
  assign dump_nxt  = dump_ptr + DONE_ONE;
  assign dump_last = (dump_nxt == dump_len_q);

  // CPU leaves reset only in RUN; a dump request pulls it down immediately
  assign cpu_reset_n = (state == RUN) && !dump_req;
  assign cpu_dout    = mem_dout;
  assign state_o     = state;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state decode and stream-ready
  always_comb begin
    state_d    = state;
    s_ready    = 1'b0;
    start_load = 1'b0;
    start_dump = 1'b0;
    case (state)
      IDLE: begin
        if (s_valid) begin
          state_d    = LOAD;
          start_load = 1'b1;
        end else if (dump_req) begin
          start_dump = 1'b1;
        end
      end
      LOAD: begin
        s_ready = 1'b1;
        if (s_valid && s_last) state_d = LOADED;
      end
      LOADED: begin
        if (dump_req) begin
          start_dump = 1'b1;
        end else if (run_req) begin
          state_d = RUN;
        end else if (s_valid) begin
          state_d    = LOAD;
          start_load = 1'b1;
        end
      end
      RUN:       if (dump_req) start_dump = 1'b1;
      DUMP_RD:   state_d = DUMP_WAIT;
      DUMP_WAIT: state_d = DUMP_OUT;
      DUMP_OUT:  if (m_ready) state_d = dump_last ? LOADED : DUMP_RD;
      default:   state_d = IDLE;
    endcase
    // Empty dump bounces straight back without touching the stream
    if (start_dump) state_d = (dump_len == '0) ? LOADED : DUMP_RD;
  end

  // Loader datapath: load pointer, registered SRAM request, dump stream
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_ptr     <= '0;
      ld_addr    <= '0;
      ld_din     <= '0;
      ld_we      <= 1'b0;
      load_err   <= 1'b0;
      dump_ptr   <= '0;
      dump_len_q <= '0;
      m_valid    <= 1'b0;
      m_data     <= '0;
    end else begin
      ld_we <= 1'b0;
      if (start_load) begin
        ld_ptr   <= '0;
        load_err <= 1'b0;
      end
      if (load_wr) begin
        ld_we   <= 1'b1;
        ld_addr <= ld_ptr;
        ld_din  <= s_data;
        // No wrap: park on the last address and flag a too-long image
        if (ld_ptr == LAST_ADDR) begin
          if (!s_last) load_err <= 1'b1;
        end else begin
          ld_ptr <= ld_ptr + AWIDTH'(1);
        end
      end
      if (start_dump) begin
        dump_ptr   <= '0;
        dump_len_q <= dump_len;
        ld_addr    <= '0;
      end
      if (state == DUMP_WAIT) begin
        m_data  <= mem_dout;
        m_valid <= 1'b1;
      end
      if (state == DUMP_OUT && m_ready) begin
        m_valid  <= 1'b0;
        dump_ptr <= dump_nxt;
        ld_addr  <= dump_nxt[AWIDTH-1:0];
      end
    end
  end

`ifdef LOAD_CHECKSUM_EN
  // Running sum of words committed to SRAM during the current load
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           load_sum <= '0;
    else if (start_load) load_sum <= '0;
    else if (load_wr)    load_sum <= load_sum + s_data;
  end
`endif

  mano_mem_mux #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_mem_mux (
    .run_sel  (state == RUN),
    .cpu_ar   (cpu_ar),
    .cpu_din  (cpu_din),
    .cpu_we   (cpu_we),
    .ld_addr  (ld_addr),
    .ld_din   (ld_din),
    .ld_we    (ld_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_we   (mem_we)
  );

endmodule

// File: tb/tb_mano_boot_loader.sv
// Self-checking bench for mano_boot_loader: synchronous SRAM model plus an
// image/array reference of what memory must hold and what a dump must emit.
// Define LOAD_CHECKSUM_EN to also check load_sum.
module tb_mano_boot_loader;
  import mano_pkg::*;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int MS = 4096;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s_valid = 1'b0, s_last = 1'b0, run_req = 1'b0, dump_req = 1'b0;
  logic          m_ready = 1'b0, cpu_we = 1'b0;
  logic [DW-1:0] s_data = '0, cpu_din = '0;
  logic [AW:0]   dump_len = '0;
  logic [AW-1:0] cpu_ar = '0;
  logic          s_ready, m_valid, cpu_reset_n, mem_we, load_err;
  logic [DW-1:0] m_data, cpu_dout, mem_din;
  logic [DW-1:0] mem_dout = '0;
  logic [AW-1:0] mem_addr;
  logic [2:0]    state_o;
`ifdef LOAD_CHECKSUM_EN
  logic [DW-1:0] load_sum;
`endif

  int n_chk = 0;
  int n_err = 0;

  logic [DW-1:0] sram    [MS];
  logic [DW-1:0] ref_mem [MS];
  logic [DW-1:0] img [$];
  logic          mem_init = 1'b1;

  always #5 clk = ~clk;

  // Single-port synchronous SRAM, preloaded with a recognisable pattern
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < MS; i++) sram[i] <= 32'hC0DE_0000 + i;
      mem_init <= 1'b0;
    end else if (mem_we) begin
      sram[mem_addr] <= mem_din;
    end
    mem_dout <= sram[mem_addr];
  end

  mano_boot_loader dut (
    .clk         (clk),
    .reset       (reset),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .run_req     (run_req),
    .dump_req    (dump_req),
    .dump_len    (dump_len),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .cpu_reset_n (cpu_reset_n),
    .cpu_ar      (cpu_ar),
    .cpu_din     (cpu_din),
    .cpu_we      (cpu_we),
    .cpu_dout    (cpu_dout),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_we      (mem_we),
    .mem_dout    (mem_dout),
`ifdef LOAD_CHECKSUM_EN
    .load_sum    (load_sum),
`endif
    .state_o     (state_o),
    .load_err    (load_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One stream beat; entered and left on a falling edge
  task automatic send_beat(input logic [DW-1:0] d, input logic last);
    int budget = 50;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) chk("s_ready_timeout", 64'(s_ready), 64'(1));
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Stream img[] and compare SRAM / flags against what the image implies
  task automatic load_img(input int gapmax);
    int            n  = img.size();
    int            nw = (n < MS) ? n : MS;
    logic [DW-1:0] sum = '0;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gapmax)) @(negedge clk);
      send_beat(img[i], i == n - 1);
    end
    @(negedge clk);
    for (int i = 0; i < nw; i++) begin
      ref_mem[i] = img[i];
      sum += img[i];
    end
    chk("load_state", 64'(state_o), 64'(LOADED));
    chk("load_err", 64'(load_err), 64'(n > MS));
    chk("cpu_held", 64'(cpu_reset_n), 64'(0));
    if (n <= 64) begin
      for (int i = 0; i < n; i++) chk("sram_img", 64'(sram[i]), 64'(ref_mem[i]));
    end else begin
      chk("sram_first", 64'(sram[0]), 64'(img[0]));
      chk("sram_last", 64'(sram[MS-1]), 64'(img[MS-1]));
    end
`ifdef LOAD_CHECKSUM_EN
    chk("load_sum", 64'(load_sum), 64'(sum));
`endif
  endtask

  task automatic run_cpu();
    run_req = 1'b1;
    #1 chk("rst_before_run", 64'(cpu_reset_n), 64'(0));
    @(negedge clk);
    run_req = 1'b0;
    chk("run_state", 64'(state_o), 64'(RUN));
    chk("cpu_released", 64'(cpu_reset_n), 64'(1));
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_we = 1'b1; cpu_ar = a; cpu_din = d;
    #1 chk("mux_addr", 64'(mem_addr), 64'(a));
    @(negedge clk);
    cpu_we = 1'b0;
    ref_mem[a] = d;
    chk("cpu_wr", 64'(sram[a]), 64'(d));
  endtask

  // Receive len words with m_ready toggling (mode 0) or random (mode 1)
  task automatic collect(input int len, input int mode);
    int            got = 0;
    int            budget = 8 * len + 20;
    logic          hold = 1'b0;
    logic          tog = 1'b0;
    logic [DW-1:0] held = '0;
    while (got < len && budget > 0) begin
      m_ready = (mode == 0) ? tog : 1'($urandom_range(0, 1));
      tog = ~tog;
      #1;
      if (hold) begin
        chk("hold_valid", 64'(m_valid), 64'(1));
        chk("hold_data", 64'(m_data), 64'(held));
      end
      if (m_valid && m_ready) begin
        chk("dump_word", 64'(m_data), 64'(ref_mem[got]));
        got++;
        hold = 1'b0;
      end else begin
        hold = m_valid;
        held = m_data;
      end
      @(negedge clk);
      budget--;
    end
    m_ready = 1'b0;
    if (got < len) chk("dump_timeout", 64'(got), 64'(len));
  endtask

  task automatic dump(input int len, input int mode, input logic cpu_wr,
                      input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic with_run);
    dump_req = 1'b1;
    run_req  = with_run;
    dump_len = (AW+1)'(len);
    if (cpu_wr) begin
      cpu_we = 1'b1; cpu_ar = wa; cpu_din = wd;
    end
    #1 chk("cpu_rst_drop", 64'(cpu_reset_n), 64'(0));
    @(negedge clk);
    dump_req = 1'b0;
    run_req  = 1'b0;
    cpu_we   = 1'b0;
    if (cpu_wr) begin
      ref_mem[wa] = wd;
      chk("wr_during_dump", 64'(sram[wa]), 64'(wd));
    end
    if (len == 0) chk("dump0_valid", 64'(m_valid), 64'(0));
    else          collect(len, mode);
    chk("dump_end_state", 64'(state_o), 64'(LOADED));
    chk("dump_end_valid", 64'(m_valid), 64'(0));
    chk("dump_end_cpu", 64'(cpu_reset_n), 64'(0));
  endtask

  initial begin
    logic [DW-1:0] w0, w1;
    for (int i = 0; i < MS; i++) ref_mem[i] = 32'hC0DE_0000 + i;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_state", 64'(state_o), 64'(IDLE));
    chk("rst_cpu", 64'(cpu_reset_n), 64'(0));
    chk("rst_s_ready", 64'(s_ready), 64'(0));
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_m_data", 64'(m_data), 64'(0));
    chk("rst_mem_we", 64'(mem_we), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_din", 64'(mem_din), 64'(0));
    chk("rst_load_err", 64'(load_err), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    // Directed load, run, CPU write, dump from RUN with toggling ready
    img = '{32'h1000, 32'h2001, 32'h7020, 32'h4003};
    load_img(0);
    run_cpu();
    cpu_write(12'd10, 32'hABCD);
    run_req = 1'b1;
    @(negedge clk);
    run_req = 1'b0;
    chk("run_req_ignored", 64'(state_o), 64'(RUN));
    dump(4, 0, 1'b1, 12'd20, $urandom, 1'b0);
    dump(0, 1, 1'b0, '0, '0, 1'b0);

    // Overflow: MS+2 words
    img.delete();
    for (int i = 0; i < MS + 2; i++) img.push_back($urandom);
    load_img(0);
    img = '{$urandom, $urandom, $urandom};
    load_img(1);

    // dump_req beats run_req in LOADED
    dump(3, 1, 1'b0, '0, '0, 1'b1);

    // Reset in the middle of a load: the in-flight write is cancelled
    w0 = $urandom; w1 = $urandom;
    send_beat(w0, 1'b0);
    send_beat(w1, 1'b0);
    #1 chk("mid_we_pending", 64'(mem_we), 64'(1));
    reset = 1'b1;
    #1;
    chk("mid_rst_state", 64'(state_o), 64'(IDLE));
    chk("mid_rst_s_ready", 64'(s_ready), 64'(0));
    chk("mid_rst_mem_we", 64'(mem_we), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ref_mem[0] = w0;
    chk("mid_sram0", 64'(sram[0]), 64'(w0));
    chk("mid_sram1", 64'(sram[1]), 64'(ref_mem[1]));
    chk("mid_load_err", 64'(load_err), 64'(0));
    @(negedge clk);

    // Checksum wrap case
    img = '{32'hFFFF_FFFF, 32'h0000_0002};
    load_img(2);
`ifdef LOAD_CHECKSUM_EN
    chk("sum_wrap", 64'(load_sum), 64'(32'h1));
`endif

    // Randomised loads, runs and dumps
    for (int it = 0; it < 8; it++) begin
      int n = $urandom_range(1, 24);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back($urandom);
      load_img(3);
      dump($urandom_range(0, n + 2), 1, 1'b0, '0, '0, 1'b0);
      if (it[0]) begin
        run_cpu();
        for (int k = 0; k < 3; k++) cpu_write(AW'($urandom_range(0, 31)), $urandom);
        dump($urandom_range(1, 8), 1, 1'b1, AW'($urandom_range(0, 31)), $urandom, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
